// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master round-robin arbiter for an 8-bit Wishbone bus.
// m0 (SPI bridge) and m1 (command port) share one slave-side bus. Ownership is
// registered; the slave-side signals are muxed combinationally from the grant.
// Optional stall timeout: define WB_ARB_TIMEOUT_EN to add the stall counter and
// the ERR state. Without it a stalled slave holds the bus indefinitely.
module wb_arbiter_2m #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   // master 0
   input  logic [7:0] m0_adr_i,
   input  logic [7:0] m0_dat_i,
   input  logic       m0_we_i,
   input  logic       m0_cyc_i,
   input  logic       m0_stb_i,
   output logic [7:0] m0_dat_o,
   output logic       m0_ack_o,
   output logic       m0_err_o,
   // master 1
   input  logic [7:0] m1_adr_i,
   input  logic [7:0] m1_dat_i,
   input  logic       m1_we_i,
   input  logic       m1_cyc_i,
   input  logic       m1_stb_i,
   output logic [7:0] m1_dat_o,
   output logic       m1_ack_o,
   output logic       m1_err_o,
   // slave side
   output logic [7:0] s_adr_o,
   output logic [7:0] s_dat_o,
   output logic       s_we_o,
   output logic       s_cyc_o,
   output logic       s_stb_o,
   input  logic [7:0] s_dat_i,
   input  logic       s_ack_i,
   // one-hot owner, 00 = idle
   output logic [1:0] grant_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN  = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [1:0] ERR  = 2'd2;
`endif

   // Elaboration-time range check keeps a bad override from building silently.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 1..65535");
   end

   logic [1:0] state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       last_q, last_d;   // 1 = m1 owned last, so m0 wins the next tie
   logic       owner_cyc;
   logic       owner_stb;
   logic       bus_live;         // low only while a timed-out owner still holds the grant

   assign owner_cyc = (grant_q[0] & m0_cyc_i) | (grant_q[1] & m1_cyc_i);
   assign owner_stb = (grant_q[0] & m0_stb_i) | (grant_q[1] & m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  err_q, err_d;
   logic        stall;
   logic        timeout_hit;

   assign bus_live = (state_q != ERR);

   // Counter runs only while the owner strobes into a silent slave; anything
   // else (ack, strobe low, not in OWN) clears it, so entering OWN starts at 0.
   assign stall       = (state_q == OWN) & owner_cyc & owner_stb & ~s_ack_i;
   assign timeout_hit = stall & ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);
   assign cnt_d       = stall ? (cnt_q + 16'd1) : 16'h0000;

   // Stall counter and single-cycle error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
         err_q <= 2'b00;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign m0_err_o = err_q[0];
   assign m1_err_o = err_q[1];
`else
   assign bus_live = 1'b1;
   assign m0_err_o = 1'b0;
   assign m1_err_o = 1'b0;
`endif

   // Next-state logic: arbitration in IDLE, release on owner cyc low.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
      err_d   = 2'b00;
`endif
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               grant_d = last_q ? 2'b01 : 2'b10;
               state_d = OWN;
            end else if (m0_cyc_i) begin
               grant_d = 2'b01;
               state_d = OWN;
            end else if (m1_cyc_i) begin
               grant_d = 2'b10;
               state_d = OWN;
            end
         end
         OWN: begin
            if (!owner_cyc) begin
               state_d = IDLE;
               grant_d = 2'b00;
               last_d  = grant_q[1];
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               state_d = ERR;
               err_d   = grant_q;
            end
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         ERR: begin
            // Grant is kept until the owner abandons its cycle.
            if (!owner_cyc) begin
               state_d = IDLE;
               grant_d = 2'b00;
               last_d  = grant_q[1];
            end
         end
`endif
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // State, grant and round-robin history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Slave-side one-hot mux; grant 00 forces every field to zero.
   always_comb begin
      s_adr_o = ({8{grant_q[0]}} & m0_adr_i) | ({8{grant_q[1]}} & m1_adr_i);
      s_dat_o = ({8{grant_q[0]}} & m0_dat_i) | ({8{grant_q[1]}} & m1_dat_i);
      s_we_o  = (grant_q[0] & m0_we_i) | (grant_q[1] & m1_we_i);
      s_cyc_o = bus_live & owner_cyc;
      s_stb_o = bus_live & owner_cyc & owner_stb;
   end

   // Return path: only the owner sees ack and read data.
   always_comb begin
      m0_ack_o = s_ack_i & grant_q[0];
      m1_ack_o = s_ack_i & grant_q[1];
      m0_dat_o = {8{grant_q[0]}} & s_dat_i;
      m1_dat_o = {8{grant_q[1]}} & s_dat_i;
   end

   assign grant_o = grant_q;

endmodule
